// File: rtl/axi_lite_mem_responder.sv
// AXI4-Lite terminating slave backed by a small word-addressed register memory.
// Independent aw/w holding registers feed a single B register; reads use a
// single R register. Out-of-range words answer SLVERR and never touch memory.

package axi_lite_mem_responder_pkg;
   typedef struct packed {
      logic [31:0] addr;
      logic [2:0]  prot;
   } ax_chan_t;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
   } w_chan_t;

   typedef struct packed {
      logic [1:0] resp;
   } b_chan_t;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
   } r_chan_t;

   typedef struct packed {
      ax_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ax_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    w_ready;
      b_chan_t b;
      logic    b_valid;
      logic    ar_ready;
      r_chan_t r;
      logic    r_valid;
   } resp_t;
endpackage

module axi_lite_mem_responder #(
   parameter int unsigned NoWords   = 16,
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32,
   parameter type         req_t     = axi_lite_mem_responder_pkg::req_t,
   parameter type         resp_t    = axi_lite_mem_responder_pkg::resp_t
) (
   input  logic  clk_i,
   input  logic  rst_ni,
   input  req_t  slv_req_i,
   output resp_t slv_resp_o
);

   localparam int unsigned StrbW = DataWidth / 8;
   localparam int unsigned OffW  = $clog2(StrbW);
   localparam int unsigned IdxW  = (NoWords > 1) ? $clog2(NoWords) : 1;
   localparam logic [1:0]  RespOkay   = 2'b00;
   localparam logic [1:0]  RespSlverr = 2'b10;

   function automatic logic addr_in_range(input logic [AddrWidth-1:0] addr);
      return (addr >> OffW) < AddrWidth'(NoWords);
   endfunction

   function automatic logic [IdxW-1:0] addr_idx(input logic [AddrWidth-1:0] addr);
      return IdxW'(addr >> OffW);
   endfunction

   logic                 aw_valid_q, aw_valid_d;
   logic [AddrWidth-1:0] aw_addr_q, aw_addr_d;
   logic                 w_valid_q, w_valid_d;
   logic [DataWidth-1:0] w_data_q, w_data_d;
   logic [StrbW-1:0]     w_strb_q, w_strb_d;
   logic                 b_valid_q, b_valid_d;
   logic [1:0]           b_resp_q, b_resp_d;
   logic                 r_valid_q, r_valid_d;
   logic [DataWidth-1:0] r_data_q, r_data_d;
   logic [1:0]           r_resp_q, r_resp_d;
   logic [DataWidth-1:0] mem_q [NoWords];
   logic [DataWidth-1:0] mem_d [NoWords];

   logic                 aw_ready, w_ready, ar_ready;
   logic                 aw_hs, w_hs, ar_hs;
   logic                 aw_avail, w_avail, commit;
   logic [AddrWidth-1:0] wr_addr;
   logic [DataWidth-1:0] wr_data;
   logic [StrbW-1:0]     wr_strb;
   logic                 wr_in_range;

   // prot carries no meaning for a plain memory
   logic unused_prot;
   assign unused_prot = ^{slv_req_i.aw.prot, slv_req_i.ar.prot};

   // Write-side handshakes and commit decision; a just-arriving beat bypasses its holding reg
   always_comb begin
      aw_ready    = !aw_valid_q;
      w_ready     = !w_valid_q;
      aw_hs       = slv_req_i.aw_valid & aw_ready;
      w_hs        = slv_req_i.w_valid & w_ready;
      aw_avail    = aw_valid_q | aw_hs;
      w_avail     = w_valid_q | w_hs;
      commit      = aw_avail & w_avail & (!b_valid_q | slv_req_i.b_ready);
      wr_addr     = aw_valid_q ? aw_addr_q : slv_req_i.aw.addr;
      wr_data     = w_valid_q ? w_data_q : slv_req_i.w.data;
      wr_strb     = w_valid_q ? w_strb_q : slv_req_i.w.strb;
      wr_in_range = addr_in_range(wr_addr);
   end

   // Holding registers and the B response register
   always_comb begin
      aw_valid_d = aw_valid_q;
      aw_addr_d  = aw_addr_q;
      w_valid_d  = w_valid_q;
      w_data_d   = w_data_q;
      w_strb_d   = w_strb_q;
      b_valid_d  = b_valid_q;
      b_resp_d   = b_resp_q;
      if (commit) begin
         aw_valid_d = 1'b0;
         w_valid_d  = 1'b0;
      end else begin
         if (aw_hs) begin
            aw_valid_d = 1'b1;
            aw_addr_d  = slv_req_i.aw.addr;
         end
         if (w_hs) begin
            w_valid_d = 1'b1;
            w_data_d  = slv_req_i.w.data;
            w_strb_d  = slv_req_i.w.strb;
         end
      end
      if (commit) begin
         b_valid_d = 1'b1;
         b_resp_d  = wr_in_range ? RespOkay : RespSlverr;
      end else if (slv_req_i.b_ready) begin
         b_valid_d = 1'b0;
      end
   end

   // Byte-strobed memory update on commit
   always_comb begin
      mem_d = mem_q;
      if (commit && wr_in_range) begin
         for (int i = 0; i < int'(StrbW); i++) begin
            if (wr_strb[i]) begin
               mem_d[addr_idx(wr_addr)][8*i +: 8] = wr_data[8*i +: 8];
            end
         end
      end
   end

   // Read path samples mem_q, so a same-edge write is seen only by later reads
   always_comb begin
      ar_ready  = !r_valid_q | slv_req_i.r_ready;
      ar_hs     = slv_req_i.ar_valid & ar_ready;
      r_valid_d = r_valid_q;
      r_data_d  = r_data_q;
      r_resp_d  = r_resp_q;
      if (ar_hs) begin
         r_valid_d = 1'b1;
         if (addr_in_range(slv_req_i.ar.addr)) begin
            r_data_d = mem_q[addr_idx(slv_req_i.ar.addr)];
            r_resp_d = RespOkay;
         end else begin
            r_data_d = '0;
            r_resp_d = RespSlverr;
         end
      end else if (slv_req_i.r_ready) begin
         r_valid_d = 1'b0;
      end
   end

   // Response struct assembly
   always_comb begin
      slv_resp_o          = '0;
      slv_resp_o.aw_ready = aw_ready;
      slv_resp_o.w_ready  = w_ready;
      slv_resp_o.b.resp   = b_resp_q;
      slv_resp_o.b_valid  = b_valid_q;
      slv_resp_o.ar_ready = ar_ready;
      slv_resp_o.r.data   = r_data_q;
      slv_resp_o.r.resp   = r_resp_q;
      slv_resp_o.r_valid  = r_valid_q;
   end

   // State registers; reset drops all pending traffic and clears the memory
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         aw_valid_q <= 1'b0;
         aw_addr_q  <= '0;
         w_valid_q  <= 1'b0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         b_valid_q  <= 1'b0;
         b_resp_q   <= '0;
         r_valid_q  <= 1'b0;
         r_data_q   <= '0;
         r_resp_q   <= '0;
         for (int i = 0; i < int'(NoWords); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         aw_valid_q <= aw_valid_d;
         aw_addr_q  <= aw_addr_d;
         w_valid_q  <= w_valid_d;
         w_data_q   <= w_data_d;
         w_strb_q   <= w_strb_d;
         b_valid_q  <= b_valid_d;
         b_resp_q   <= b_resp_d;
         r_valid_q  <= r_valid_d;
         r_data_q   <= r_data_d;
         r_resp_q   <= r_resp_d;
         mem_q      <= mem_d;
      end
   end

endmodule
